// File: rtl/simd256_pkg.sv
// Shared types and sizes for the simd256 message sequencer.
//   state_e      : sequencer states
//   BLK_W/WORD_W : block and message-word widths
//   IV_DEFAULT   : chaining value loaded on start unless overridden
`timescale 1ns/1ps
package simd256_pkg;

  localparam int unsigned BLK_W         = 512;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORDS_PER_BLK = 16;
  localparam int unsigned WCNT_W        = $clog2(WORDS_PER_BLK);
  localparam int unsigned HASH_W        = BLK_W / 2;
  localparam int unsigned CORE_LATENCY  = 44;

  localparam logic [BLK_W-1:0] IV_DEFAULT = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/simd256_blk_asm.sv
// Packs 32-bit message words into a 512-bit block, first word most significant.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : restart packing at word 0
//   wr_i       : accept word_i this cycle
//   word_i     : message word
//   last_i     : word_i is the last word of the message
//   done_c     : this accepted word completes the block (16th word or last)
//   blk_nxt_c  : block contents as they will be after this cycle's write
`timescale 1ns/1ps
module simd256_blk_asm
  import simd256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              last_i,
  output logic              done_c,
  output logic [BLK_W-1:0]  blk_nxt_c
);

  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  // Each write also clears every later slot, so a short last block is zero-filled
  // and stale words from the previous block never leak through.
  always_comb begin
    blk_d  = blk_q;
    wcnt_d = wcnt_q;
    if (wr_i) begin
      for (int i = 0; i < int'(WORDS_PER_BLK); i++) begin
        if (WCNT_W'(i) == wcnt_q) begin
          blk_d[BLK_W-1-WORD_W*i -: WORD_W] = word_i;
        end else if (WCNT_W'(i) > wcnt_q) begin
          blk_d[BLK_W-1-WORD_W*i -: WORD_W] = '0;
        end
      end
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
    if (clr_i) begin
      wcnt_d = '0;
    end
  end

  assign done_c    = wr_i & ((wcnt_q == WCNT_W'(WORDS_PER_BLK - 1)) | last_i);
  assign blk_nxt_c = blk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q  <= '0;
      wcnt_q <= '0;
    end else begin
      blk_q  <= blk_d;
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/simd256_ctrl.sv
// Message sequencer driving simd256_round: loads the IV, packs words into blocks,
// fires one compression per block, chains stat_o back in and presents the digest.
//   start                         : begin a new message (IDLE/DONE only)
//   din/din_valid/din_last/din_ready : message word stream
//   core_init/core_ena/core_mode/core_data/core_stat : to the round core
//   core_stat_o/core_fin          : from the round core
//   hash_o/hash_valid             : digest, held in DONE
//   busy/err                      : activity and sticky fin-timeout flag
`timescale 1ns/1ps
module simd256_ctrl
  import simd256_pkg::*;
#(
  parameter logic [BLK_W-1:0] IV          = IV_DEFAULT,
  parameter int unsigned      FIN_TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WORD_W-1:0]  din,
  input  logic               din_valid,
  input  logic               din_last,
  output logic               din_ready,
  output logic               core_init,
  output logic               core_ena,
  output logic               core_mode,
  output logic [BLK_W-1:0]   core_data,
  output logic [BLK_W-1:0]   core_stat,
  input  logic [BLK_W-1:0]   core_stat_o,
  input  logic               core_fin,
  output logic [HASH_W-1:0]  hash_o,
  output logic               hash_valid,
  output logic               busy,
  output logic               err
);

  localparam int unsigned       TCNT_W = $clog2(FIN_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TMO    = TCNT_W'(FIN_TIMEOUT);

  state_e              state_q;
  logic [BLK_W-1:0]    chain_q, core_data_q, core_stat_q;
  logic [HASH_W-1:0]   hash_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic                final_q, core_init_q, core_ena_q, din_ready_q;
  logic                hash_valid_q, busy_q, err_q;
  logic                acc_c, asm_clr_c, blk_done_c;
  logic [BLK_W-1:0]    blk_nxt_c;

  assign acc_c     = din_valid & din_ready_q;
  // Word counter restarts whenever the core hands back a chaining value.
  assign asm_clr_c = core_fin & ((state_q == ST_INIT) | (state_q == ST_WAIT));

  simd256_blk_asm u_blk_asm (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (asm_clr_c),
    .wr_i      (acc_c),
    .word_i    (din),
    .last_i    (din_last),
    .done_c    (blk_done_c),
    .blk_nxt_c (blk_nxt_c)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      chain_q      <= '0;
      core_data_q  <= '0;
      core_stat_q  <= '0;
      hash_q       <= '0;
      tcnt_q       <= '0;
      final_q      <= 1'b0;
      core_init_q  <= 1'b0;
      core_ena_q   <= 1'b0;
      din_ready_q  <= 1'b0;
      hash_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      core_init_q <= 1'b0;
      core_ena_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            core_init_q  <= 1'b1;
            core_stat_q  <= IV;
            err_q        <= 1'b0;
            hash_valid_q <= 1'b0;
            hash_q       <= '0;
            busy_q       <= 1'b1;
            tcnt_q       <= '0;
            state_q      <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (core_fin) begin
            chain_q     <= core_stat_o;
            final_q     <= 1'b0;
            din_ready_q <= 1'b1;
            state_q     <= ST_LOAD;
          end else if (tcnt_q == TMO) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        ST_LOAD: begin
          // Block is captured from the packer's next value so core_data is valid in FIRE.
          if (blk_done_c) begin
            final_q     <= din_last;
            core_data_q <= blk_nxt_c;
            core_stat_q <= chain_q;
            core_ena_q  <= 1'b1;
            din_ready_q <= 1'b0;
            state_q     <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          tcnt_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // fin takes priority over a coincident timeout
          if (core_fin) begin
            chain_q <= core_stat_o;
            if (final_q) begin
              hash_q       <= core_stat_o[BLK_W-1 -: HASH_W];
              hash_valid_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= ST_DONE;
            end else begin
              din_ready_q <= 1'b1;
              state_q     <= ST_LOAD;
            end
          end else if (tcnt_q == TMO) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign core_init  = core_init_q;
  assign core_ena   = core_ena_q;
  assign core_mode  = final_q;
  assign core_data  = core_data_q;
  assign core_stat  = core_stat_q;
  assign hash_o     = hash_q;
  assign hash_valid = hash_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_simd256_ctrl.sv
// Directed bench for simd256_ctrl with a fixed-latency round-core stub
// (init: fin after 2 cycles, stat_o = stat_i; block: fin after 44 cycles,
// stat_o = stat_i ^ data_i).
`timescale 1ns/1ps
module tb_simd256_ctrl;
  import simd256_pkg::*;

  localparam logic [BLK_W-1:0] TB_IV = {8{64'h0123_4567_89ab_cdef}};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WORD_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_last = 1'b0;
  logic              din_ready, core_init, core_ena, core_mode;
  logic [BLK_W-1:0]  core_data, core_stat;
  logic [BLK_W-1:0]  core_stat_o = '0;
  logic              core_fin = 1'b0;
  logic [HASH_W-1:0] hash_o;
  logic              hash_valid, busy, err;

  int total = 0;
  int bad   = 0;

  simd256_ctrl #(.IV(TB_IV), .FIN_TIMEOUT(63)) dut (
    .clk(clk), .rst(rst), .start(start),
    .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .core_init(core_init), .core_ena(core_ena), .core_mode(core_mode),
    .core_data(core_data), .core_stat(core_stat),
    .core_stat_o(core_stat_o), .core_fin(core_fin),
    .hash_o(hash_o), .hash_valid(hash_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Round-core stub
  int dly = 0;
  bit no_fin = 1'b0;
  always @(posedge clk) begin
    core_fin <= 1'b0;
    if (core_init) begin
      core_stat_o <= core_stat;
      dly         <= 1;
    end else if (core_ena) begin
      core_stat_o <= core_stat ^ core_data;
      dly         <= no_fin ? 0 : int'(CORE_LATENCY) - 1;
    end else if (dly == 1) begin
      core_fin <= 1'b1;
      dly      <= 0;
    end else if (dly > 1) begin
      dly <= dly - 1;
    end
  end

  // Capture each compression request
  int ena_n = 0;
  int init_n = 0;
  logic [BLK_W-1:0] cap_data [4];
  logic [BLK_W-1:0] cap_stat [4];
  logic             cap_mode [4];
  always @(negedge clk) begin
    if (core_init) init_n++;
    if (core_ena) begin
      if (ena_n < 4) begin
        cap_data[ena_n] = core_data;
        cap_stat[ena_n] = core_stat;
        cap_mode[ena_n] = core_mode;
      end
      chk("ready_in_fire", 512'(din_ready), 512'(0));
      ena_n++;
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ena_n  = 0;
    init_n = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("init_pulse", 512'(core_init), 512'(1));
    chk("init_stat", core_stat, TB_IV);
  endtask

  task automatic send(input logic [31:0] w, input bit last);
    int g = 0;
    din = w; din_valid = 1'b1; din_last = last;
    while (!din_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk("send_wait", 512'(din_ready), 512'(1));
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!hash_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("done_wait", 512'(hash_valid), 512'(1));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_state"}, 512'(dut.state_q), 512'(ST_IDLE));
    chk({tag, "_outs"}, 512'({core_init, core_ena, core_mode, din_ready, hash_valid, busy, err}), 512'(0));
    chk({tag, "_data"}, core_data, '0);
    chk({tag, "_stat"}, core_stat, '0);
    chk({tag, "_hash"}, 512'(hash_o), '0);
  endtask

  logic [BLK_W-1:0] b1, b2, t;

  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    chk_idle_zero("reset");

    // Short single-block message with zero fill
    do_start();
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b1);
    wait_done();
    b1 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 416'h0};
    t  = TB_IV ^ b1;
    chk("short_ena_n", 512'(ena_n), 512'(1));
    chk("short_data", cap_data[0], b1);
    chk("short_mode", 512'(cap_mode[0]), 512'(1));
    chk("short_stat", cap_stat[0], TB_IV);
    chk("short_hash", 512'(hash_o), 512'(t[511:256]));
    chk("short_busy", 512'(busy), 512'(0));
    repeat (5) @(negedge clk);
    chk("short_hold_v", 512'(hash_valid), 512'(1));
    chk("short_hold_h", 512'(hash_o), 512'(t[511:256]));

    // Two full blocks with chaining
    do_reset();
    do_start();
    for (int i = 0; i < 32; i++) send(32'(i), i == 31);
    wait_done();
    for (int i = 0; i < 16; i++) begin
      b1[511-32*i -: 32] = 32'(i);
      b2[511-32*i -: 32] = 32'(i + 16);
    end
    t = TB_IV ^ b1 ^ b2;
    chk("two_ena_n", 512'(ena_n), 512'(2));
    chk("two_mode0", 512'(cap_mode[0]), 512'(0));
    chk("two_mode1", 512'(cap_mode[1]), 512'(1));
    chk("two_data0", cap_data[0], b1);
    chk("two_data1", cap_data[1], b2);
    chk("two_stat0", cap_stat[0], TB_IV);
    chk("two_stat1", cap_stat[1], TB_IV ^ b1);
    chk("two_hash", 512'(hash_o), 512'(t[511:256]));

    // Backpressure: valid every other cycle, a word held during FIRE/WAIT
    do_reset();
    do_start();
    for (int i = 0; i < 16; i++) begin
      send(32'hb000_0000 + 32'(i), 1'b0);
      @(negedge clk);
    end
    din = 32'hb000_0010; din_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_ready_wait", 512'(din_ready), 512'(0));
    send(32'hb000_0010, 1'b0);
    @(negedge clk);
    send(32'hb000_0011, 1'b1);
    wait_done();
    for (int i = 0; i < 16; i++) b1[511-32*i -: 32] = 32'hb000_0000 + 32'(i);
    b2 = {32'hb000_0010, 32'hb000_0011, 448'h0};
    chk("bp_ena_n", 512'(ena_n), 512'(2));
    chk("bp_data0", cap_data[0], b1);
    chk("bp_data1", cap_data[1], b2);
    t = TB_IV ^ b1 ^ b2;
    chk("bp_hash", 512'(hash_o), 512'(t[511:256]));

    // Fin timeout
    do_reset();
    no_fin = 1'b1;
    do_start();
    send(32'hc0ff_ee00, 1'b1);
    chk("to_fire", 512'(core_ena), 512'(1));
    repeat (64) @(negedge clk);
    chk("to_err_early", 512'(err), 512'(0));
    @(negedge clk);
    chk("to_err", 512'(err), 512'(1));
    chk("to_state", 512'(dut.state_q), 512'(ST_IDLE));
    chk("to_hv", 512'(hash_valid), 512'(0));
    chk("to_busy", 512'(busy), 512'(0));
    no_fin = 1'b0;

    // Restart clears err; start during LOAD ignored
    do_start();
    chk("to_err_clr", 512'(err), 512'(0));
    send(32'haaaa_0001, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_init", 512'(core_init), 512'(0));
    chk("ign_state", 512'(dut.state_q), 512'(ST_LOAD));
    send(32'haaaa_0002, 1'b0);
    send(32'haaaa_0003, 1'b1);
    wait_done();
    b1 = {32'haaaa_0001, 32'haaaa_0002, 32'haaaa_0003, 416'h0};
    t  = TB_IV ^ b1;
    chk("ign_init_n", 512'(init_n), 512'(2));
    chk("ign_data", cap_data[1], b1);
    chk("ign_hash", 512'(hash_o), 512'(t[511:256]));

    // Reset 10 cycles after core_ena; later fin must be ignored
    do_start();
    send(32'hdead_beef, 1'b1);
    repeat (10) @(negedge clk);
    do_reset();
    chk_idle_zero("rst_wait");
    repeat (40) @(negedge clk);
    chk_idle_zero("rst_late_fin");
    do_start();
    send(32'h0000_0001, 1'b0);
    send(32'h8000_0000, 1'b1);
    wait_done();
    b1 = {32'h0000_0001, 32'h8000_0000, 448'h0};
    t  = TB_IV ^ b1;
    chk("rst_ena_n", 512'(ena_n), 512'(1));
    chk("rst_data", cap_data[0], b1);
    chk("rst_hash", 512'(hash_o), 512'(t[511:256]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
